// File: rtl/div_request_arbiter.sv
// div_request_arbiter
//   Shares one iterative divider between N_REQ requesters. Requests are
//   arbitrated round-robin. The winner's operands are latched and the divider
//   is started with a one-cycle pulse. The arbiter then waits for a rising
//   edge on DONE and returns the quotient and remainder with a one-cycle VALID.
//   A zero divisor is answered locally and never reaches the divider. A
//   watchdog answers with ERR if the divider hangs.
//
// Handshake: a requester raises REQ (level) with its operands valid. It holds
//   REQ until its VALID bit pulses. The operands are only needed in the cycle
//   in which GNT is taken. GNT stays high from the grant until VALID ends, and
//   at most one GNT bit and one VALID bit are ever set.
//
// Ports
//   CLK, RSTn            clock (rising edge), async active-low reset
//   REQ                  per-requester request level
//   NUM_IN, DEN_IN       packed operands, requester i at [i*tamanyo +: tamanyo]
//   GNT, VALID           one-hot grant / one-cycle result strobe
//   COC_OUT, RES_OUT     quotient / remainder, qualified by VALID
//   DZ, ERR              divide-by-zero / watchdog flags, qualified by VALID
//   DIV_START            one-cycle start pulse to the divider
//   DIV_NUM, DIV_DEN     operands to the divider, stable for the whole operation
//   DIV_COC, DIV_RES     divider results
//   DIV_DONE             divider completion (edge-detected)
module div_request_arbiter #(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ*tamanyo-1:0]   NUM_IN,
    input  logic [N_REQ*tamanyo-1:0]   DEN_IN,
    output logic [N_REQ-1:0]           GNT,
    output logic [N_REQ-1:0]           VALID,
    output logic [tamanyo-1:0]         COC_OUT,
    output logic [tamanyo-1:0]         RES_OUT,
    output logic                       DZ,
    output logic                       ERR,
    output logic                       DIV_START,
    output logic [tamanyo-1:0]         DIV_NUM,
    output logic [tamanyo-1:0]         DIV_DEN,
    input  logic [tamanyo-1:0]         DIV_COC,
    input  logic [tamanyo-1:0]         DIV_RES,
    input  logic                       DIV_DONE
);

    localparam int RR_W = $clog2(N_REQ);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

    state_t              r_state, w_state;
    logic [RR_W-1:0]     r_rr, w_rr;
    logic [RR_W-1:0]     r_gidx, w_gidx;
    logic                r_done_q;
    logic [WD_W-1:0]     r_wdog, w_wdog;
    logic [N_REQ-1:0]    r_gnt, w_gnt, r_valid, w_valid;
    logic [tamanyo-1:0]  r_coc, w_coc, r_res, w_res;
    logic [tamanyo-1:0]  r_num, w_num, r_den, w_den;
    logic                r_dz, w_dz, r_err, w_err, r_start, w_start;

    logic                w_found;
    logic [RR_W-1:0]     w_pick;
    logic [RR_W:0]       w_sum;
    logic [RR_W-1:0]     w_cand;
    logic [tamanyo-1:0]  w_sel_num, w_sel_den;
    logic                w_done_edge, w_wd_expired;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr} + (RR_W+1)'(k);
            if (w_sum >= (RR_W+1)'(N_REQ)) begin
                w_sum = w_sum - (RR_W+1)'(N_REQ);
            end
            w_cand = w_sum[RR_W-1:0];
            if (!w_found && REQ[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_sel_num = NUM_IN[w_pick*tamanyo +: tamanyo];
    assign w_sel_den = DEN_IN[w_pick*tamanyo +: tamanyo];

    // done_q follows DONE in every state, so a level that is already high
    // when WAIT is entered never looks like an edge.
    assign w_done_edge  = DIV_DONE & ~r_done_q;
    assign w_wd_expired = (TIMEOUT != 0) && (r_wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_state = r_state;
        w_rr    = r_rr;
        w_gidx  = r_gidx;
        w_wdog  = r_wdog;
        w_gnt   = r_gnt;
        w_valid = '0;
        w_coc   = r_coc;
        w_res   = r_res;
        w_num   = r_num;
        w_den   = r_den;
        w_dz    = r_dz;
        w_err   = r_err;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gidx        = w_pick;
                    w_gnt         = '0;
                    w_gnt[w_pick] = 1'b1;
                    w_num         = w_sel_num;
                    w_den         = w_sel_den;
                    w_dz          = 1'b0;
                    w_err         = 1'b0;
                    if (w_sel_den != '0) begin
                        w_start = 1'b1;
                        w_state = ST_LAUNCH;
                    end else begin
                        // Zero divisor answered locally; VALID follows in RESP.
                        w_coc   = '1;
                        w_res   = w_sel_num;
                        w_dz    = 1'b1;
                        w_state = ST_RESP;
                    end
                end
            end
            ST_LAUNCH: begin
                w_wdog  = '0;
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_edge) begin
                    w_coc   = DIV_COC;
                    w_res   = DIV_RES;
                    w_valid = r_gnt;
                    w_state = ST_RESP;
                end else if (w_wd_expired) begin
                    w_coc   = '0;
                    w_res   = '0;
                    w_err   = 1'b1;
                    w_valid = r_gnt;
                    w_state = ST_RESP;
                end else if (TIMEOUT != 0) begin
                    w_wdog = r_wdog + WD_W'(1);
                end
            end
            ST_RESP: begin
                // Entered from WAIT with VALID already set; entered from IDLE
                // (zero divisor) without it, so VALID is raised here first.
                if (r_valid == '0) begin
                    w_valid = r_gnt;
                end else begin
                    w_gnt   = '0;
                    w_rr    = (r_gidx == RR_W'(N_REQ - 1)) ? '0 : r_gidx + RR_W'(1);
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= ST_IDLE;
            r_rr     <= '0;
            r_gidx   <= '0;
            r_done_q <= 1'b0;
            r_wdog   <= '0;
            r_gnt    <= '0;
            r_valid  <= '0;
            r_coc    <= '0;
            r_res    <= '0;
            r_num    <= '0;
            r_den    <= '0;
            r_dz     <= 1'b0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rr     <= w_rr;
            r_gidx   <= w_gidx;
            r_done_q <= DIV_DONE;
            r_wdog   <= w_wdog;
            r_gnt    <= w_gnt;
            r_valid  <= w_valid;
            r_coc    <= w_coc;
            r_res    <= w_res;
            r_num    <= w_num;
            r_den    <= w_den;
            r_dz     <= w_dz;
            r_err    <= w_err;
            r_start  <= w_start;
        end
    end

    assign GNT       = r_gnt;
    assign VALID     = r_valid;
    assign COC_OUT   = r_coc;
    assign RES_OUT   = r_res;
    assign DZ        = r_dz;
    assign ERR       = r_err;
    assign DIV_START = r_start;
    assign DIV_NUM   = r_num;
    assign DIV_DEN   = r_den;

endmodule

// File: tb/tb_div_request_arbiter.sv
// Testbench for div_request_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model of the arbiter.
module tb_div_request_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 64;
    localparam int PW = N + 2*W + 2;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic [N-1:0]     REQ;
    logic [N*W-1:0]   NUM_IN, DEN_IN;
    logic [N-1:0]     GNT, VALID;
    logic [W-1:0]     COC_OUT, RES_OUT, DIV_NUM, DIV_DEN, DIV_COC, DIV_RES;
    logic             DZ, ERR, DIV_START, DIV_DONE;

    div_request_arbiter #(.tamanyo(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .NUM_IN(NUM_IN), .DEN_IN(DEN_IN),
        .GNT(GNT), .VALID(VALID), .COC_OUT(COC_OUT), .RES_OUT(RES_OUT),
        .DZ(DZ), .ERR(ERR), .DIV_START(DIV_START), .DIV_NUM(DIV_NUM),
        .DIV_DEN(DIV_DEN), .DIV_COC(DIV_COC), .DIV_RES(DIV_RES), .DIV_DONE(DIV_DONE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- bench state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [PW-1:0] exp_q[$];
    int           m_rr, g_idx, g_cyc, g_lat, g_starts, starts_seen, cyc;
    int           served[N];
    int           n_valid;
    int           rate;
    logic [N-1:0] prev_gnt, prev_valid, s_req;
    logic [N*W-1:0] s_num, s_den;
    bit           dv_hang, dv_stale;
    int           dv_lat;

    // ---------------- divider behavioural model ----------------
    initial begin : divider_model
        bit           busy;
        int           cnt;
        logic [W-1:0] q, r;
        bit           pulse;
        busy = 0; cnt = 0; q = '0; r = '0;
        DIV_DONE = 1'b0; DIV_COC = '0; DIV_RES = '0;
        forever begin
            @(posedge CLK); #1;
            pulse = 0;
            if (!RSTn) begin
                busy = 0;
            end else if (busy) begin
                if (cnt == 0) begin
                    pulse = 1; DIV_COC = q; DIV_RES = r; busy = 0;
                end else begin
                    cnt--;
                end
            end
            if (RSTn && DIV_START && !dv_hang && DIV_DEN != '0) begin
                busy = 1; cnt = dv_lat;
                q = DIV_NUM / DIV_DEN; r = DIV_NUM % DIV_DEN;
            end
            if (dv_stale) begin
                DIV_COC = 32'hDEAD_BEEF; DIV_RES = 32'h0BAD_F00D;
            end
            DIV_DONE = pulse | dv_stale;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        exp_q.delete();
        m_rr = 0; prev_gnt = '0; prev_valid = '0;
        starts_seen = 0; g_starts = 0; g_lat = -1;
    endtask

    // Reference model: runs at the negative edge, after the DUT has settled.
    task automatic monitor();
        int           g;
        logic [N-1:0] eg;
        logic [W-1:0] num, den;
        logic [PW-1:0] e;
        cyc++;
        check("invariants", {$onehot0(GNT), $onehot0(VALID), !(DZ && ERR), (VALID & ~GNT) == '0}, 4'b1111);
        if (!RSTn) begin
            check("reset_outs", {GNT, VALID, DIV_START, DZ, ERR, COC_OUT, RES_OUT, DIV_NUM, DIV_DEN}, '0);
        end else begin
            if (prev_gnt == '0) begin
                g  = rr_pick(s_req, m_rr);
                eg = (g < 0) ? '0 : (N'(1) << g);
                check("grant", GNT, eg);
                if (g >= 0) begin
                    num = s_num[g*W +: W];
                    den = s_den[g*W +: W];
                    if (den == '0) begin
                        exp_q.push_back({eg, {W{1'b1}}, num, 1'b1, 1'b0});
                        g_lat = 1;
                    end else if (dv_hang) begin
                        exp_q.push_back({eg, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1});
                        g_lat = TO + 1;
                    end else begin
                        exp_q.push_back({eg, num / den, num % den, 1'b0, 1'b0});
                        g_lat = -1;
                    end
                    g_idx = g; g_cyc = cyc; starts_seen = 0;
                    g_starts = (den != '0) ? 1 : 0;
                    check("start_at_grant", DIV_START, (den != '0));
                end
            end else if (prev_valid != '0) begin
                check("gnt_release", GNT, '0);
            end
            if (DIV_START) starts_seen++;
            if (VALID != '0) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", VALID, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {VALID, COC_OUT, RES_OUT, DZ, ERR}, e);
                    check("start_count", starts_seen, g_starts);
                    if (g_lat >= 0) check("latency", cyc - g_cyc, g_lat);
                    m_rr = (g_idx + 1) % N;
                    served[g_idx]++;
                    n_valid++;
                end
            end
        end
        prev_gnt = GNT; prev_valid = VALID;
    endtask

    // ---------------- driver tasks ----------------
    task automatic raise(input int i, input logic [W-1:0] num, input logic [W-1:0] den);
        REQ[i] = 1'b1;
        NUM_IN[i*W +: W] = num;
        DEN_IN[i*W +: W] = den;
    endtask

    function automatic logic [W-1:0] rand_den();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel < 6) return W'($urandom_range(1, 20));
        return $urandom | 32'h1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (VALID[i]) REQ[i] = 1'b0;
            if (rate > 0 && !REQ[i] && $urandom_range(1, 100) <= rate) begin
                raise(i, $urandom, rand_den());
            end
        end
        dv_lat = $urandom_range(0, 6);
    endtask

    task automatic step();
        @(posedge CLK);
        s_req = REQ; s_num = NUM_IN; s_den = DEN_IN;
        #1;
        drive_reqs();
        @(negedge CLK);
        monitor();
    endtask

    task automatic apply_reset();
        RSTn = 1'b0;
        REQ  = '0;
        reset_model();
        step();
        step();
        RSTn = 1'b1;
        reset_model();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(REQ == '0 && GNT == '0 && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_reached", (REQ == '0 && GNT == '0 && exp_q.size() == 0), 1'b1);
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (n_valid < target && n < budget) begin
            step();
            n++;
        end
        check("ops_reached", n_valid, target);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        REQ = '0; NUM_IN = '0; DEN_IN = '0;
        rate = 0; dv_hang = 0; dv_stale = 0; dv_lat = 2; cyc = 0; n_valid = 0;
        g_idx = 0; g_cyc = 0;
        for (int i = 0; i < N; i++) served[i] = 0;
        s_req = '0; s_num = '0; s_den = '0;

        // Basic operation
        apply_reset();
        raise(0, 32'd4, 32'd2);
        wait_idle(100);

        // Two simultaneous requests after reset
        apply_reset();
        raise(0, 32'd100, 32'd7);
        raise(1, 32'd9, 32'd3);
        wait_idle(200);

        // All requesters held continuously: fairness
        apply_reset();
        for (int i = 0; i < N; i++) served[i] = 0;
        n_valid = 0;
        rate = 100;
        run_until(12, 600);
        for (int i = 0; i < N; i++) check("fair_share", served[i], 3);
        rate = 0;
        wait_idle(600);

        // Divide by zero, answered locally
        raise(2, 32'd17, 32'd0);
        wait_idle(50);

        // Hung divider: watchdog, then a normal operation
        dv_hang = 1;
        raise(1, W'($urandom_range(1, 1000)), W'($urandom_range(1, 50)));
        wait_idle(300);
        dv_hang = 0;
        raise(1, 32'd55, 32'd6);
        wait_idle(100);

        // Asynchronous reset in the middle of WAIT, then a stale DONE level
        dv_hang = 1;
        raise(3, 32'd1234, 32'd5);
        repeat (10) step();
        #2 RSTn = 1'b0;
        #1 check("async_reset", {GNT, VALID, DIV_START}, '0);
        REQ = '0; dv_hang = 0;
        reset_model();
        step();
        step();
        RSTn = 1'b1;
        reset_model();
        dv_stale = 1;
        repeat (3) step();
        dv_stale = 0;
        step();
        raise(3, 32'd10, 32'd3);
        wait_idle(100);

        // Random traffic
        rate = 40;
        repeat (400) step();
        rate = 0;
        wait_idle(1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
